mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Sequences and shares the single byte-wide unified memory (4096 x 8) between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Each 32-bit access is split into four sequential byte transfers, big-endian (MIPS order).
- Returns an ack pulse when the access is complete; the pipeline stalls on the requester until ack.

Parameters:
- ADDR_W, 32, requester address width
- DATA_W, 32, requester data width (word)
- MEM_AW, 12, memory byte-address width (depth 2**MEM_AW = 4096)
- BYTE_W, 8, memory data width; bytes per word BPW = DATA_W/BYTE_W = 4

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  DATA_W  fetched word, valid with if_ack
- if_ack  out  1  one-cycle completion pulse
- if_err  out  1  with if_ack: misaligned/out-of-range, no access made
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  DATA_W  store word
- dm_rdata  out  DATA_W  load word, valid with dm_ack
- dm_ack  out  1  one-cycle completion pulse
- dm_err  out  1  with dm_ack: misaligned/out-of-range, no access made
- mem_en  out  1  memory byte access strobe
- mem_we  out  1  memory byte write enable
- mem_addr  out  MEM_AW  memory byte address
- mem_wdata  out  BYTE_W  memory write byte
- mem_rdata  in  BYTE_W  read byte; synchronous memory, valid the cycle after mem_en
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. All outputs 0 (acks, errs, rdata, mem_*, busy). Reset mid-transfer aborts immediately; bytes already written stay written; no ack is issued.
- FSM states: IDLE, XFER, RTAIL, ACK.
- IDLE, arbitration: fixed priority, dm over if, evaluated when the FSM is in IDLE. The winner's address, we and wdata are latched as the grant.
- Error check: addr[1:0]!=0 or addr >= 2**MEM_AW gives an error. Next cycle = ACK state with ack=1 and err=1 to the winner; rdata unchanged; no mem_en.
- Cycle numbering: c0 = IDLE cycle in which the request is accepted. c1..c4 = XFER, byte index i=0..3, mem_en=1, mem_addr=base+i.
- Store: mem_we=1, mem_wdata = wdata[31-8i -: 8], so byte 0 is the MSB.
- Load: byte i arrives on mem_rdata in the cycle after its issue and is captured into rdata[31-8i -: 8] at the end of that cycle. c5 = RTAIL, which captures byte 3.
- Ack timing: load ack in c6; store ack in c5 (XFER goes straight to ACK). Ack lasts exactly one cycle; rdata is registered and held until the next load completes for that port.
- Cycle after ACK: IDLE. A request seen there is treated as new, so requesters must drop req or present the next request in the cycle after ack. Back-to-back throughput: store 6 cycles, load 7 cycles.
- Inactive port: its ack/err stay 0; its req is ignored until the FSM returns to IDLE, regardless of how its inputs change.
- Outside XFER: mem_en=mem_we=0; mem_addr and mem_wdata hold their last values.
- Address arithmetic: base = addr[MEM_AW-1:0]. Aligned addresses cannot wrap, so no carry logic is required.
- Starvation: IF may wait indefinitely while dm_req is continuously asserted. This is accepted, because the MEM stage blocks the pipeline anyway.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, three extra outputs are added, each 32-bit, reset to 0 and saturating at all-ones:
  - if_grant_cnt: IF grants
  - dm_grant_cnt: dm grants, including error grants
  - if_wait_cnt: cycles with if_req=1 while a dm grant is active or dm wins arbitration
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Store then load: dm store addr 0x010, wdata 0xDEADBEEF -> mem bytes 0x010..0x013 = DE,AD,BE,EF, dm_ack in c5. Then dm load 0x010 -> dm_rdata=0xDEADBEEF, dm_ack in c6.
- Fetch of preloaded memory 0x000..0x003 = 20,08,00,05 -> if_rdata=0x20080005, if_ack in c6, mem_we=0 throughout.
- Simultaneous request: if_req and dm_req (load 0x010) asserted in the same cycle -> dm served first, if_ack 7 cycles after dm_ack; with the feature on, if_wait_cnt=7.
- Errors: dm store addr 0x012 -> dm_ack=dm_err=1 in c1, no mem_en. if addr 0x1000 -> if_err=1, memory unchanged.
- Reset mid-store: rst_n low in c2 of a store to 0x020 -> outputs 0 immediately, busy=0, no ack. Only byte 0x020 written; after release a new request is accepted normally.
- Mid-transfer hold-off: if_req asserted during a dm transfer -> no if_ack until the cycle after dm_ack plus a full fetch; mem_addr sequence contiguous per transfer.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Byte-serial arbiter sharing one 4096x8 synchronous memory between IF fetches and MEM-stage
// loads/stores; words move big-endian, four bytes per access. Optional counters: MEM_ARB_STATS_EN.
module mips_mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned MEM_AW = 12,
   parameter int unsigned BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   output logic              if_err,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              dm_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [BYTE_W-1:0] mem_wdata,
   input  logic [BYTE_W-1:0] mem_rdata,
   output logic              busy
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]       if_grant_cnt,
   output logic [31:0]       dm_grant_cnt,
   output logic [31:0]       if_wait_cnt
`endif
);

   localparam int unsigned BPW      = DATA_W / BYTE_W;
   localparam int unsigned IDX_W    = $clog2(BPW);
   localparam int unsigned LAST_I   = BPW - 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_I);
   localparam logic [DATA_W-1:0] BYTE_MASK = {{(DATA_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}};

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StXfer  = 2'd1;
   localparam logic [1:0] StRtail = 2'd2;
   localparam logic [1:0] StAck   = 2'd3;

   logic [1:0]              state_q, state_d;
   logic                    gnt_dm_q, gnt_we_q, err_q;
   logic [MEM_AW-1:IDX_W]   base_q;
   logic [DATA_W-1:0]       wdata_q, rbuf_q, rbuf_d;
   logic [IDX_W-1:0]        idx_q, cap_idx;
   logic [DATA_W-1:0]       if_rdata_q, dm_rdata_q;
   logic [MEM_AW-1:0]       hold_addr_q;
   logic [BYTE_W-1:0]       hold_wdata_q, wr_byte;
   logic [DATA_W-1:0]       wr_shift;
   int unsigned             cap_sh;
   logic                    xfer, accept, req_bad, cap_en;
   logic [ADDR_W-1:0]       req_addr;

   // dm always wins when both ports ask in the same IDLE cycle
   always_comb begin
      accept   = (state_q == StIdle) && (dm_req || if_req);
      req_addr = dm_req ? dm_addr : if_addr;
      req_bad  = (|req_addr[ADDR_W-1:MEM_AW]) || (|req_addr[IDX_W-1:0]);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = req_bad ? StAck : StXfer;
         StXfer:  if (idx_q == LAST_IDX) state_d = gnt_we_q ? StAck : StRtail;
         StRtail: state_d = StAck;
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Byte idx goes out MSB first; load data lags its issue by one cycle.
   always_comb begin
      xfer     = (state_q == StXfer);
      wr_shift = wdata_q << (BYTE_W * 32'(idx_q));
      wr_byte  = wr_shift[DATA_W-1 -: BYTE_W];
      cap_en   = (xfer && !gnt_we_q && (idx_q != '0)) || (state_q == StRtail);
      cap_idx  = xfer ? idx_q - IDX_W'(1) : LAST_IDX;
      cap_sh   = BYTE_W * (LAST_I - 32'(cap_idx));
      rbuf_d   = (rbuf_q & ~(BYTE_MASK << cap_sh)) | (DATA_W'(mem_rdata) << cap_sh);
   end

   always_comb begin
      mem_en    = xfer;
      mem_we    = xfer && gnt_we_q;
      mem_addr  = xfer ? {base_q, idx_q} : hold_addr_q;
      mem_wdata = mem_we ? wr_byte : hold_wdata_q;
      dm_ack    = (state_q == StAck) && gnt_dm_q;
      if_ack    = (state_q == StAck) && !gnt_dm_q;
      dm_err    = dm_ack && err_q;
      if_err    = if_ack && err_q;
      dm_rdata  = dm_rdata_q;
      if_rdata  = if_rdata_q;
      busy      = (state_q != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         gnt_dm_q     <= 1'b0;
         gnt_we_q     <= 1'b0;
         err_q        <= 1'b0;
         base_q       <= '0;
         wdata_q      <= '0;
         idx_q        <= '0;
         rbuf_q       <= '0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            gnt_dm_q <= dm_req;
            gnt_we_q <= dm_req && dm_we;
            err_q    <= req_bad;
            base_q   <= req_addr[MEM_AW-1:IDX_W];
            wdata_q  <= dm_wdata;
            idx_q    <= '0;
         end
         if (xfer) begin
            idx_q       <= idx_q + IDX_W'(1);
            hold_addr_q <= mem_addr;
            if (gnt_we_q) hold_wdata_q <= wr_byte;
         end
         if (cap_en) rbuf_q <= rbuf_d;
         if (state_q == StRtail) begin
            if (gnt_dm_q) dm_rdata_q <= rbuf_d;
            else          if_rdata_q <= rbuf_d;
         end
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic if_waiting;

   always_comb begin
      if_waiting = if_req && (((state_q != StIdle) && gnt_dm_q) ||
                              ((state_q == StIdle) && dm_req));
   end

   // Saturating counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_grant_cnt <= '0;
         dm_grant_cnt <= '0;
         if_wait_cnt  <= '0;
      end else begin
         if (accept && !dm_req && (if_grant_cnt != '1)) if_grant_cnt <= if_grant_cnt + 32'd1;
         if (accept && dm_req && (dm_grant_cnt != '1))  dm_grant_cnt <= dm_grant_cnt + 32'd1;
         if (if_waiting && (if_wait_cnt != '1))         if_wait_cnt  <= if_wait_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed, table-driven bench for mips_mem_arbiter with a behavioural 4096x8 synchronous memory.
module tb_mips_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack, if_err;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ack, dm_err;
   logic        mem_en, mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic        busy;
`ifdef MEM_ARB_STATS_EN
   logic [31:0] if_grant_cnt, dm_grant_cnt, if_wait_cnt;
`endif

   int total = 0;
   int bad = 0;
   logic init_mem = 1'b1;
   logic [7:0] mem [0:4095];
   logic [31:0] exp_if_rd = '0;
   logic [31:0] exp_dm_rd = '0;

   mips_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_STATS_EN
      , .if_grant_cnt(if_grant_cnt), .dm_grant_cnt(dm_grant_cnt), .if_wait_cnt(if_wait_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] preload(input int a);
      case (a)
         0: return 8'h20;  1: return 8'h08;  2: return 8'h00;  3: return 8'h05;
         4: return 8'h24;  5: return 8'h09;  6: return 8'h00;  7: return 8'h0A;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 4096; i++) mem[i] <= preload(i);
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          dm;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
      int          lat;
   } txn_t;

   txn_t vec [10];

   // Called on a negedge in an IDLE cycle; returns on the negedge of the following IDLE cycle.
   task automatic run_txn(input txn_t t);
      int n = 0;
      int k = 0;
      bit got = 0;
      if (t.dm) begin
         dm_req = 1'b1; dm_we = t.we; dm_addr = t.addr; dm_wdata = t.wdata;
      end else begin
         if_req = 1'b1; if_addr = t.addr;
      end
      while (!got && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (mem_en) begin
            check("mem_addr_seq", {20'h0, mem_addr}, {20'h0, t.addr[11:0]} + k);
            check("mem_we", {31'h0, mem_we}, {31'h0, t.we});
            k++;
         end
         if (dm_ack || if_ack) got = 1;
      end
      if (!got) check("ack_timeout", 32'(n), 32'(t.lat));
      if (!t.err && !t.we) begin
         if (t.dm) exp_dm_rd = t.rdata;
         else      exp_if_rd = t.rdata;
      end
      check("latency", 32'(n), 32'(t.lat));
      check("dm_ack", {31'h0, dm_ack}, {31'h0, t.dm});
      check("if_ack", {31'h0, if_ack}, {31'h0, !t.dm});
      check("err", {31'h0, t.dm ? dm_err : if_err}, {31'h0, t.err});
      check("dm_rdata", dm_rdata, exp_dm_rd);
      check("if_rdata", if_rdata, exp_if_rd);
      check("mem_en_count", 32'(k), t.err ? 32'd0 : 32'd4);
      dm_req = 1'b0; if_req = 1'b0;
      @(negedge clk);
      check("ack_one_cycle", {30'h0, dm_ack, if_ack}, 32'h0);
      if (t.dm && t.we && !t.err)
         for (int i = 0; i < 4; i++)
            check("store_byte", {24'h0, mem[t.addr[11:0] + 12'(i)]},
                  {24'h0, t.wdata[31-8*i -: 8]});
   endtask

   initial begin
      int n;
      int k;
      bit got;
      bit early;
`ifdef MEM_ARB_STATS_EN
      logic [31:0] w0, ig0, dg0;
`endif
      vec[0] = '{1, 1, 32'h010, 32'hDEADBEEF, 32'h0, 0, 5};
      vec[1] = '{1, 0, 32'h010, 32'h0, 32'hDEADBEEF, 0, 6};
      vec[2] = '{0, 0, 32'h000, 32'h0, 32'h20080005, 0, 6};
      vec[3] = '{1, 1, 32'h012, 32'h12345678, 32'h0, 1, 1};
      vec[4] = '{0, 0, 32'h1000, 32'h0, 32'h0, 1, 1};
      vec[5] = '{1, 1, 32'hFFC, 32'h01020304, 32'h0, 0, 5};
      vec[6] = '{0, 0, 32'hFFC, 32'h0, 32'h01020304, 0, 6};
      vec[7] = '{1, 0, 32'h004, 32'h0, 32'h2409000A, 0, 6};
      vec[8] = '{1, 0, 32'h80000000, 32'h0, 32'h0, 1, 1};
      vec[9] = '{0, 0, 32'h002, 32'h0, 32'h0, 1, 1};

      repeat (3) @(posedge clk);
      init_mem = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_acks", {28'h0, if_ack, if_err, dm_ack, dm_err}, 32'h0);
      check("rst_mem", {18'h0, mem_en, mem_we, mem_addr}, 32'h0);
      check("rst_wdata", {24'h0, mem_wdata}, 32'h0);
      check("rst_rdata", if_rdata | dm_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_txn(vec[i]);
      check("err_no_write", {24'h0, mem[12'h012]}, 32'h000000BE);

      // Simultaneous requests: dm load first, fetch follows.
`ifdef MEM_ARB_STATS_EN
      w0 = if_wait_cnt; ig0 = if_grant_cnt; dg0 = dm_grant_cnt;
`endif
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h010;
      if_req = 1'b1; if_addr = 32'h000;
      n = 0; got = 0; early = 0;
      while (!got && n < 20) begin
         @(posedge clk); n++; @(negedge clk);
         if (if_ack) early = 1;
         if (dm_ack) got = 1;
      end
      check("simul_dm_lat", 32'(n), 32'd6);
      check("simul_dm_rdata", dm_rdata, 32'hDEADBEEF);
      check("simul_if_held", {31'h0, early}, 32'h0);
      dm_req = 1'b0;
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(posedge clk); n++; @(negedge clk);
         if (if_ack) got = 1;
      end
      check("simul_if_lat", 32'(n), 32'd7);
      check("simul_if_rdata", if_rdata, 32'h20080005);
`ifdef MEM_ARB_STATS_EN
      check("stat_if_wait", if_wait_cnt - w0, 32'd7);
      check("stat_if_grant", if_grant_cnt - ig0, 32'd1);
      check("stat_dm_grant", dm_grant_cnt - dg0, 32'd1);
`endif
      if_req = 1'b0;
      @(negedge clk);

      // Fetch raised mid-store must wait for the store and then run a full fetch.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h030; dm_wdata = 32'hCAFEF00D;
      n = 0; k = 0; got = 0; early = 0;
      while (!got && n < 20) begin
         @(posedge clk); n++; @(negedge clk);
         if (n == 2) begin if_req = 1'b1; if_addr = 32'h000; end
         if (if_ack) early = 1;
         if (mem_en) begin
            check("hold_dm_addr", {20'h0, mem_addr}, 32'h030 + k); k++;
         end
         if (dm_ack) got = 1;
      end
      check("hold_dm_lat", 32'(n), 32'd5);
      check("hold_if_held", {31'h0, early}, 32'h0);
      dm_req = 1'b0;
      n = 0; k = 0; got = 0;
      while (!got && n < 20) begin
         @(posedge clk); n++; @(negedge clk);
         if (mem_en) begin
            check("hold_if_addr", {20'h0, mem_addr}, 32'(k)); k++;
            check("hold_if_we", {31'h0, mem_we}, 32'h0);
         end
         if (if_ack) got = 1;
      end
      check("hold_if_lat", 32'(n), 32'd7);
      check("hold_if_rdata", if_rdata, 32'h20080005);
      if_req = 1'b0;
      @(negedge clk);

      // Reset asserted in c2 of a store to 0x020.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h020; dm_wdata = 32'h11223344;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_acks", {30'h0, dm_ack, if_ack}, 32'h0);
      check("midrst_mem", {19'h0, mem_en, mem_addr}, 32'h0);
      check("midrst_rdata", dm_rdata | if_rdata, 32'h0);
      dm_req = 1'b0;
      exp_dm_rd = '0; exp_if_rd = '0;
      repeat (2) @(negedge clk);
      check("midrst_byte0", {24'h0, mem[12'h020]}, 32'h11);
      check("midrst_byte1", {24'h0, mem[12'h021]}, 32'h00);
      rst_n = 1'b1;
      @(negedge clk);
      run_txn('{1, 0, 32'h020, 32'h0, 32'h11000000, 0, 6});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
